// File: rtl/vmem_hs_bridge.sv
`default_nettype none
// ============================================================================
// vmem_hs_bridge : DMA req/ack <-> valid/ready mapping plus kernel-op framing
// Revision       : 1.0
// ============================================================================
module vmem_hs_bridge #(
  parameter int NDMA    = 4,
  parameter int SELW    = 4,
  parameter int THRESH  = 8,
  parameter int LENW    = 16,
  parameter int CREDITS = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [NDMA-1:0] t_idma_req,
  output logic [NDMA-1:0] t_idma_ack,
  output logic [NDMA-1:0] idma_valid,
  input  logic [NDMA-1:0] idma_ready,
  input  logic [NDMA-1:0] odma_valid,
  output logic [NDMA-1:0] odma_ready,
  output logic [NDMA-1:0] i_odma_req,
  input  logic [NDMA-1:0] i_odma_ack,
  input  logic            t_ka_req,
  output logic            t_ka_ack,
  input  logic [SELW-1:0] k_ctrl,
  input  logic [LENW-1:0] k_len,
  input  logic            t_ivs_req,
  output logic            t_ivs_ack,
  output logic            tvs_valid,
  input  logic            tvs_ready,
  input  logic            ivs_valid,
  output logic            ivs_ready,
  output logic            i_ovs_req,
  input  logic            i_ovs_ack,
  output logic            busy,
  output logic            op_done
);

  localparam int OW = $clog2(CREDITS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state;
  logic            mode;
  logic [LENW-1:0] rem;
  logic [OW-1:0]   outst;

  logic credit_ok;
  logic beat;
  logic ret_take;
  logic drain_exit;

  assign idma_valid = t_idma_req;
  assign t_idma_ack = idma_ready;
  assign i_odma_req = odma_valid;
  assign odma_ready = i_odma_ack;

  assign busy = (state != IDLE);

  always_comb begin
    credit_ok = (32'(outst) < CREDITS);
    tvs_valid = 1'b0;
    if (state == RUN) begin
      tvs_valid = mode ? (t_ka_req & credit_ok) : (t_ka_req & t_ivs_req);
    end
    beat      = tvs_valid & tvs_ready;
    t_ka_ack  = beat;
    t_ivs_ack = beat & ~mode;
    // Fused mode swallows returned beats; generate mode forwards them.
    i_ovs_req  = mode & ivs_valid;
    ivs_ready  = mode ? i_ovs_ack : 1'b1;
    ret_take   = mode & ivs_valid & ivs_ready & (outst != '0);
    drain_exit = ~mode | (outst == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      mode    <= 1'b0;
      rem     <= '0;
      outst   <= '0;
      op_done <= 1'b0;
    end else begin
      op_done <= 1'b0;
      // A return alongside a beat leaves the credit count unchanged.
      if (mode) begin
        if (beat && !ret_take) begin
          outst <= outst + OW'(1);
        end else if (ret_take && !beat) begin
          outst <= outst - OW'(1);
        end
      end
      case (state)
        IDLE: begin
          if (t_ka_req) begin
            mode  <= (32'(k_ctrl) >= THRESH);
            rem   <= k_len;
            state <= (k_len != '0) ? RUN : DRAIN;
          end
        end
        RUN: begin
          if (beat) begin
            rem <= rem - LENW'(1);
            if (rem == LENW'(1)) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (drain_exit) begin
            state   <= IDLE;
            op_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vmem_hs_bridge.sv
`default_nettype none
// Scoreboard bench for vmem_hs_bridge: expected beats/completions are queued
// by the stimulus and consumed by a negedge monitor.
module tb_vmem_hs_bridge;

  localparam int NDMA = 4;
  localparam int SELW = 4;
  localparam int LENW = 16;

  localparam int K_BEAT = 0;
  localparam int K_DONE = 1;

  typedef struct {
    int   kind;
    logic ivs_ack;
  } exp_t;

  logic            clk;
  logic            reset_n;
  logic [NDMA-1:0] t_idma_req, t_idma_ack, idma_valid, idma_ready;
  logic [NDMA-1:0] odma_valid, odma_ready, i_odma_req, i_odma_ack;
  logic            t_ka_req, t_ka_ack;
  logic [SELW-1:0] k_ctrl;
  logic [LENW-1:0] k_len;
  logic            t_ivs_req, t_ivs_ack, tvs_valid, tvs_ready;
  logic            ivs_valid, ivs_ready, i_ovs_req, i_ovs_ack;
  logic            busy, op_done;

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];
  exp_t mon_e;
  int   beat_cnt  = 0;
  int   ret_cnt   = 0;
  int   model_out = 0;
  bit   gen_mode  = 1'b0;

  vmem_hs_bridge #(
    .NDMA(NDMA), .SELW(SELW), .THRESH(8), .LENW(LENW), .CREDITS(4)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .t_idma_req(t_idma_req), .t_idma_ack(t_idma_ack),
    .idma_valid(idma_valid), .idma_ready(idma_ready),
    .odma_valid(odma_valid), .odma_ready(odma_ready),
    .i_odma_req(i_odma_req), .i_odma_ack(i_odma_ack),
    .t_ka_req(t_ka_req), .t_ka_ack(t_ka_ack),
    .k_ctrl(k_ctrl), .k_len(k_len),
    .t_ivs_req(t_ivs_req), .t_ivs_ack(t_ivs_ack),
    .tvs_valid(tvs_valid), .tvs_ready(tvs_ready),
    .ivs_valid(ivs_valid), .ivs_ready(ivs_ready),
    .i_ovs_req(i_ovs_req), .i_ovs_ack(i_ovs_ack),
    .busy(busy), .op_done(op_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input logic ack);
    exp_t e;
    e.kind    = kind;
    e.ivs_ack = ack;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic obs();
    @(negedge clk);
    #1;
  endtask

  // Drives an op until op_done; entered and left just after a rising edge.
  task automatic run_until_done(input int nb, input bit toggle, input bit drive_ret,
                                input bit fused_chk, input int maxc, input string name);
    for (int k = 0; k < maxc; k++) begin
      t_ka_req  = (beat_cnt < nb);
      tvs_ready = toggle ? (k % 2 == 0) : 1'b1;
      if (drive_ret) ivs_valid = (model_out > 0);
      obs();
      if (fused_chk) begin
        chk({name, "_ivs_ready"}, 32'(ivs_ready), 32'd1);
        chk({name, "_ovs_req"}, 32'(i_ovs_req), 32'd0);
      end
      if (op_done) begin
        t_ka_req = 1'b0;
        step();
        return;
      end
      step();
    end
    tests++;
    fails++;
    $display("FAIL %s: got no op_done within %0d cycles, expected op_done", name, maxc);
  endtask

  // Monitor: consumes the scoreboard and tracks outstanding generated beats.
  always @(negedge clk) begin
    if (reset_n) begin
      tests++;
      if ((t_ka_ack || t_ivs_ack) && !(tvs_valid && tvs_ready)) begin
        fails++;
        $display("FAIL ack_without_beat: got ka_ack=%b ivs_ack=%b, expected 0 0", t_ka_ack, t_ivs_ack);
      end
      if (tvs_valid && tvs_ready) begin
        beat_cnt++;
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL sb_beat: got unexpected beat, expected none");
        end else begin
          mon_e = sb.pop_front();
          if (mon_e.kind != K_BEAT || t_ka_ack !== 1'b1 || t_ivs_ack !== mon_e.ivs_ack) begin
            fails++;
            $display("FAIL sb_beat: got kind=%0d ka_ack=%b ivs_ack=%b, expected kind=%0d ka_ack=1 ivs_ack=%b",
                     K_BEAT, t_ka_ack, t_ivs_ack, mon_e.kind, mon_e.ivs_ack);
          end
        end
      end
      if (op_done) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL sb_done: got unexpected op_done, expected none");
        end else begin
          mon_e = sb.pop_front();
          if (mon_e.kind != K_DONE) begin
            fails++;
            $display("FAIL sb_done: got op_done, expected event kind %0d", mon_e.kind);
          end
        end
      end
      if (gen_mode) begin
        if ((tvs_valid && tvs_ready) && !(ivs_valid && i_ovs_ack && model_out > 0)) begin
          model_out++;
        end else if (!(tvs_valid && tvs_ready) && (ivs_valid && i_ovs_ack && model_out > 0)) begin
          model_out--;
          ret_cnt++;
        end else if ((tvs_valid && tvs_ready) && (ivs_valid && i_ovs_ack && model_out > 0)) begin
          ret_cnt++;
        end
      end
    end
  end

  initial begin
    reset_n    = 1'b0;
    t_idma_req = 4'b1010; idma_ready = 4'b0110;
    odma_valid = 4'b0101; i_odma_ack = 4'b1100;
    t_ka_req   = 1'b1; t_ivs_req = 1'b1; tvs_ready = 1'b1;
    ivs_valid  = 1'b1; i_ovs_ack = 1'b1;
    k_ctrl     = 4'd3; k_len = 16'd5;
    #3;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tvs_valid", 32'(tvs_valid), 32'd0);
    chk("rst_ka_ack", 32'(t_ka_ack), 32'd0);
    chk("rst_ivs_ack", 32'(t_ivs_ack), 32'd0);
    chk("rst_ovs_req", 32'(i_ovs_req), 32'd0);
    chk("rst_ivs_ready", 32'(ivs_ready), 32'd1);
    chk("rst_op_done", 32'(op_done), 32'd0);
    chk("dma_idma_valid", 32'(idma_valid), 32'h0a);
    chk("dma_idma_ack", 32'(t_idma_ack), 32'h06);
    chk("dma_odma_req", 32'(i_odma_req), 32'h05);
    chk("dma_odma_ready", 32'(odma_ready), 32'h0c);
    t_idma_req = 4'b0101; idma_ready = 4'b1001;
    odma_valid = 4'b0011; i_odma_ack = 4'b1110;
    #1;
    chk("dma2_idma_valid", 32'(idma_valid), 32'h05);
    chk("dma2_idma_ack", 32'(t_idma_ack), 32'h09);
    chk("dma2_odma_req", 32'(i_odma_req), 32'h03);
    chk("dma2_odma_ready", 32'(odma_ready), 32'h0e);
    t_ka_req = 1'b0; ivs_valid = 1'b0; i_ovs_ack = 1'b0; tvs_ready = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    step();

    // Fused op, k_ctrl=3, k_len=5, tvs_ready toggling.
    gen_mode = 1'b0; k_ctrl = 4'd3; k_len = 16'd5; t_ivs_req = 1'b1; ivs_valid = 1'b1;
    repeat (5) push(K_BEAT, 1'b1);
    push(K_DONE, 1'b0);
    beat_cnt = 0;
    run_until_done(5, 1'b1, 1'b0, 1'b1, 40, "fused");
    chk("fused_beats", 32'(beat_cnt), 32'd5);

    // Generate op, k_ctrl=9, k_len=10, returns held off.
    gen_mode = 1'b1; k_ctrl = 4'd9; k_len = 16'd10; i_ovs_ack = 1'b0; ivs_valid = 1'b1;
    tvs_ready = 1'b1; model_out = 0; ret_cnt = 0; beat_cnt = 0;
    repeat (10) push(K_BEAT, 1'b0);
    push(K_DONE, 1'b0);
    t_ka_req = 1'b1;
    repeat (5) step();
    obs();
    chk("gen_credit_stall", 32'(tvs_valid), 32'd0);
    chk("gen_stall_beats", 32'(beat_cnt), 32'd4);
    chk("gen_ovs_req", 32'(i_ovs_req), 32'd1);
    chk("gen_ivs_ready", 32'(ivs_ready), 32'd0);
    chk("gen_busy", 32'(busy), 32'd1);
    step(); i_ovs_ack = 1'b1; obs();
    chk("gen_boundary_no_reopen", 32'(tvs_valid), 32'd0);
    step(); tvs_ready = 1'b0; obs();
    chk("gen_reopen", 32'(tvs_valid), 32'd1);
    step(); tvs_ready = 1'b1; obs();
    chk("gen_simul_at_2", 32'(tvs_valid), 32'd1);
    step(); i_ovs_ack = 1'b0; obs();
    chk("gen_issue_3", 32'(tvs_valid), 32'd1);
    step(); obs();
    chk("gen_issue_4", 32'(tvs_valid), 32'd1);
    step(); obs();
    chk("gen_outst_held_2", 32'(tvs_valid), 32'd0);
    chk("gen_beats_7", 32'(beat_cnt), 32'd7);
    step(); i_ovs_ack = 1'b1;
    run_until_done(10, 1'b0, 1'b0, 1'b0, 40, "gen");
    chk("gen_returns_at_done", 32'(ret_cnt), 32'd10);
    chk("gen_beats", 32'(beat_cnt), 32'd10);
    i_ovs_ack = 1'b0; ivs_valid = 1'b0; gen_mode = 1'b0;
    step();

    // Zero-length op.
    k_ctrl = 4'd3; k_len = 16'd0; tvs_ready = 1'b1; t_ivs_req = 1'b1;
    push(K_DONE, 1'b0);
    t_ka_req = 1'b1; obs();
    chk("zl_busy_n", 32'(busy), 32'd0);
    step(); t_ka_req = 1'b0; obs();
    chk("zl_busy_n1", 32'(busy), 32'd1);
    chk("zl_tvs_valid", 32'(tvs_valid), 32'd0);
    chk("zl_done_n1", 32'(op_done), 32'd0);
    step(); obs();
    chk("zl_done_n2", 32'(op_done), 32'd1);
    chk("zl_busy_n2", 32'(busy), 32'd0);
    step(); obs();
    chk("zl_done_n3", 32'(op_done), 32'd0);
    step();

    // Reset mid-op with rem=3, outst=2.
    gen_mode = 1'b1; k_ctrl = 4'd12; k_len = 16'd5; i_ovs_ack = 1'b0; ivs_valid = 1'b1;
    tvs_ready = 1'b1; beat_cnt = 0; model_out = 0;
    repeat (2) push(K_BEAT, 1'b0);
    t_ka_req = 1'b1;
    repeat (3) step();
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_tvs_valid", 32'(tvs_valid), 32'd0);
    chk("mid_rst_ka_ack", 32'(t_ka_ack), 32'd0);
    chk("mid_rst_ovs_req", 32'(i_ovs_req), 32'd0);
    chk("mid_rst_ivs_ready", 32'(ivs_ready), 32'd1);
    chk("mid_rst_beats", 32'(beat_cnt), 32'd2);
    gen_mode = 1'b0; model_out = 0; t_ka_req = 1'b0; ivs_valid = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); obs();
      chk("post_rst_busy", 32'(busy), 32'd0);
      chk("post_rst_done", 32'(op_done), 32'd0);
    end
    step();

    // Generate op at the THRESH boundary, k_len=1; needs cleared credits.
    gen_mode = 1'b1; k_ctrl = 4'd8; k_len = 16'd1; i_ovs_ack = 1'b1;
    beat_cnt = 0; ret_cnt = 0; model_out = 0;
    push(K_BEAT, 1'b0);
    push(K_DONE, 1'b0);
    run_until_done(1, 1'b0, 1'b1, 1'b0, 20, "post_rst_gen");
    chk("post_rst_gen_returns", 32'(ret_cnt), 32'd1);
    ivs_valid = 1'b0; i_ovs_ack = 1'b0; gen_mode = 1'b0;
    step();

    // Fused op just below THRESH, k_len=1: op_done at N+3.
    k_ctrl = 4'd7; k_len = 16'd1; t_ivs_req = 1'b1; tvs_ready = 1'b1;
    push(K_BEAT, 1'b1);
    push(K_DONE, 1'b0);
    t_ka_req = 1'b1; obs();
    step(); obs();
    chk("k1_first_beat_n1", 32'(tvs_valid), 32'd1);
    step(); t_ka_req = 1'b0; obs();
    chk("k1_drain_busy", 32'(busy), 32'd1);
    chk("k1_done_n2", 32'(op_done), 32'd0);
    step(); obs();
    chk("k1_done_n3", 32'(op_done), 32'd1);
    chk("k1_idle_n3", 32'(busy), 32'd0);
    step(); obs();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vmem_hs_bridge.md
# vmem_hs_bridge

Parametrised handshake bridge between the vector-memory DMA ports, the kernel-accelerator request interface and the vector-stream interfaces of a piston tile. DMA req/ack pairs are mapped onto valid/ready for NDMA channels. Kernel operations are framed by a small FSM that latches the operation mode and length, counts stream beats, enforces a credit limit on outstanding generated beats, and reports completion.

## Interface
- NDMA, 4, number of DMA channels in each direction
- SELW, 4, width of k_ctrl
- THRESH, 8, k_ctrl values >= THRESH select generate mode; below select fused mode
- LENW, 16, width of the operation length k_len
- CREDITS, 4, maximum outstanding generated beats (>=1)

Ports (clock and reset first; single clock, reset is asynchronous and active-low):
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- t_idma_req  in  NDMA  input-DMA requests
- t_idma_ack  out  NDMA  input-DMA acks
- idma_valid  out  NDMA  to vmem
- idma_ready  in  NDMA  from vmem
- odma_valid  in  NDMA  from vmem
- odma_ready  out  NDMA  to vmem
- i_odma_req  out  NDMA  output-DMA requests
- i_odma_ack  in  NDMA  output-DMA acks
- t_ka_req  in  1  kernel request; doubles as per-beat valid during RUN
- t_ka_ack  out  1  kernel beat ack
- k_ctrl  in  SELW  kernel control word, sampled at op start
- k_len  in  LENW  beats per op, sampled at op start
- t_ivs_req  in  1  input vector-stream request
- t_ivs_ack  out  1  input vector-stream ack
- tvs_valid  out  1  stream beat to vmem
- tvs_ready  in  1  stream beat accepted
- ivs_valid  in  1  returned stream beat from vmem
- ivs_ready  out  1  returned beat accepted
- i_ovs_req  out  1  output vector-stream request
- i_ovs_ack  in  1  output vector-stream ack
- busy  out  1  FSM not IDLE
- op_done  out  1  one-cycle completion pulse

## Operation
- DMA, per channel i, combinational: idma_valid[i]=t_idma_req[i]; t_idma_ack[i]=idma_ready[i]; i_odma_req[i]=odma_valid[i]; odma_ready[i]=i_odma_ack[i].
- Registers: state {IDLE, RUN, DRAIN}; mode (0 = fused, 1 = generate); rem (LENW bits); outst (clog2(CREDITS+1) bits); op_done.
- IDLE: tvs_valid=0, t_ka_ack=0, t_ivs_ack=0. When t_ka_req=1: mode<=(k_ctrl>=THRESH), rem<=k_len. Next state is RUN if k_len!=0, otherwise DRAIN.
- RUN, fused: tvs_valid=t_ka_req&t_ivs_req; t_ka_ack=t_ivs_ack=tvs_valid&tvs_ready.
- RUN, generate: tvs_valid=t_ka_req&(outst<CREDITS); t_ka_ack=tvs_valid&tvs_ready; t_ivs_ack=0.
- A beat is tvs_valid&tvs_ready. Each beat decrements rem. The beat that takes rem from 1 to 0 moves the FSM to DRAIN.
- DRAIN: tvs_valid=0. Exit to IDLE when outst==0 (fused mode: immediately). op_done<=1 on that transition; op_done is 0 in every other cycle.
- Return path, all states, uses latched mode:
  - Generate: i_ovs_req=ivs_valid; ivs_ready=i_ovs_ack.
  - Fused: i_ovs_req=0; ivs_ready=1; returned beats are discarded.
- outst, generate mode only:
  - +1 on a beat; −1 on ivs_valid&ivs_ready.
  - Both in the same cycle: unchanged.
  - Return with outst==0: ignored, outst stays 0.
- busy=(state!=IDLE).

## Timing
- Reset (asynchronous assert, synchronous-safe deassert): state=IDLE, mode=0, rem=0, outst=0, op_done=0.
- Output values during reset: busy=0, tvs_valid=0, t_ka_ack=0, t_ivs_ack=0, i_ovs_req=0, ivs_ready=1. DMA outputs follow their inputs.
- Reset mid-operation abandons the op. No op_done is issued; outstanding credits are cleared.
- Op start latency: t_ka_req seen in IDLE in cycle N; first beat possible in cycle N+1.
- Beat acks are combinational, zero latency, within RUN.
- op_done is asserted the cycle after DRAIN is satisfied, which is the first IDLE cycle. A new op may be accepted in that same cycle.
- Minimum op duration: k_len=1 fused → RUN 1 cycle, DRAIN 1 cycle, op_done in cycle N+3. k_len=0 → DRAIN at N+1, op_done at N+2.
- k_ctrl and k_len changes during RUN/DRAIN have no effect.
- Credit boundary: when outst==CREDITS, tvs_valid drops the same cycle. A return in that cycle does not reopen issue until the next cycle, because outst is registered.

## Test plan
- DMA mapping, NDMA=4: drive t_idma_req=4'b1010 and idma_ready=4'b0110 → idma_valid=4'b1010, t_idma_ack=4'b0110. Repeat for the odma direction.
- Fused op, k_ctrl=3, k_len=5, tvs_ready toggling 1/0, t_ivs_req=1 → exactly 5 beats, t_ivs_ack pulses coincide with t_ka_ack, op_done exactly once, ivs_ready=1 throughout, i_ovs_req=0.
- Generate op, k_ctrl=9, k_len=10, CREDITS=4, i_ovs_ack=0 → 4 beats, then tvs_valid=0 and outst=4. Release i_ovs_ack → remaining 6 beats flow. op_done only after the 10th return.
- Simultaneous issue and return at outst=2 → outst stays 2; issue continues uninterrupted.
- k_len=0 with t_ka_req → no tvs_valid; busy high for 1 cycle; op_done 2 cycles after request.
- Assert reset_n=0 in RUN with rem=3 and outst=2 → all outputs at reset values immediately; after release, busy=0, no op_done; a new op with k_len=1 completes normally.
